cell_draw_arbiter: RTL and testbench

Shares the single `vga_adapter` pixel-write port between several cell-drawing requesters, such as the head painter, the tail eraser and the fruit drawer. Each requester asks for one grid cell to be filled with a solid colour. A round-robin arbiter grants one job at a time, and a raster sequencer then issues the cell's CELL_PX×CELL_PX pixel writes, one per clock. The block sits between the game-logic requesters and the `vga_adapter` `x`/`y`/`color`/`write` inputs, in the 50 MHz domain.

---
 rtl/cell_draw_arbiter.sv | 133 +++++++++++++
 tb/tb_cell_draw_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cell_draw_arbiter.sv
// Round-robin arbiter that hands the shared VGA pixel-write port to one
// cell-fill job at a time and rasters that cell as CELL_PX x CELL_PX plots.
module cell_draw_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CELL_PX = 16,
  parameter int H_CELLS = 40,
  parameter int V_CELLS = 30,
  parameter int COLOR_W = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [6*NUM_REQ-1:0]       req_cell_x,
  input  logic [6*NUM_REQ-1:0]       req_cell_y,
  input  logic [COLOR_W*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [9:0]                 x,
  output logic [9:0]                 y,
  output logic [COLOR_W-1:0]         colour,
  output logic                       plot,
  output logic                       busy
);

  localparam int SH = $clog2(CELL_PX);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DRAW, SKIP} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, own, win, ptr_nxt;
  logic [SH-1:0]      px, py;
  logic [9:0]         base_x, win_bx, win_by;
  logic               win_skip, last_px;

  logic [5:0]         cx_a  [NUM_REQ];
  logic [5:0]         cy_a  [NUM_REQ];
  logic [COLOR_W-1:0] col_a [NUM_REQ];

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cx_a[g]  = req_cell_x[6*g +: 6];
    assign cy_a[g]  = req_cell_y[6*g +: 6];
    assign col_a[g] = req_colour[COLOR_W*g +: COLOR_W];
  end

  // Scan from lowest to highest priority so the highest-priority request wins last.
  always_comb begin : rr_pick
    int idx;
    idx = 0;
    win = ptr;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[PW'(idx)]) win = PW'(idx);
    end
  end

  assign ptr_nxt  = (win == PW'(NUM_REQ-1)) ? '0 : win + PW'(1);
  assign win_skip = (32'(cx_a[win]) >= 32'(H_CELLS)) || (32'(cy_a[win]) >= 32'(V_CELLS));
  assign win_bx   = 10'(cx_a[win]) << SH;
  assign win_by   = 10'(cy_a[win]) << SH;
  assign last_px  = (&px) & (&py);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = win_skip ? SKIP : DRAW;
      DRAW:    if (last_px) state_nxt = IDLE;
      SKIP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // x/y/colour are registered so they hold their last value whenever plot is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant  <= '0;
      done   <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      px     <= '0;
      py     <= '0;
      ptr    <= '0;
      own    <= '0;
      base_x <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: if (|req) begin
          grant <= NUM_REQ'(1) << win;
          own   <= win;
          ptr   <= ptr_nxt;
          px    <= '0;
          py    <= '0;
          if (!win_skip) begin
            plot   <= 1'b1;
            x      <= win_bx;
            y      <= win_by;
            colour <= col_a[win];
            base_x <= win_bx;
          end
        end
        DRAW: begin
          if (last_px) begin
            plot <= 1'b0;
            done <= NUM_REQ'(1) << own;
          end else begin
            px <= px + SH'(1);
            if (&px) begin
              py <= py + SH'(1);
              x  <= base_x;
              y  <= y + 10'd1;
            end else begin
              x  <= x + 10'd1;
            end
          end
        end
        SKIP:    done <= NUM_REQ'(1) << own;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_draw_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/plot/done events with
// absolute cycle stamps; a negedge monitor pops and compares what the DUT shows.
module tb_cell_draw_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [17:0] req_cell_x, req_cell_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant, done;
  logic [9:0]  x, y;
  logic [2:0]  colour;
  logic        plot, busy;

  cell_draw_arbiter #(.NUM_REQ(3), .CELL_PX(16), .H_CELLS(40), .V_CELLS(30), .COLOR_W(3)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .req_cell_x(req_cell_x), .req_cell_y(req_cell_y), .req_colour(req_colour),
    .grant(grant), .done(done), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int kind; int idx; int x; int y; int col; int cyc;} ev_t;
  ev_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic see(input int kind, input int idx, input int ex, input int ey, input int ec);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d idx=%0d x=%0d y=%0d col=%0d cyc=%0d", kind, idx, ex, ey, ec, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.idx != idx || e.x != ex || e.y != ey || e.col != ec || e.cyc != cyc) begin
        bad++;
        $display("FAIL event got(k=%0d i=%0d x=%0d y=%0d c=%0d cyc=%0d) exp(k=%0d i=%0d x=%0d y=%0d c=%0d cyc=%0d)",
                 kind, idx, ex, ey, ec, cyc, e.kind, e.idx, e.x, e.y, e.col, e.cyc);
      end
    end
  endtask

  // Event order within a cycle: grant, plot, done.
  always @(negedge clk) begin
    if (grant != 3'b000) begin
      chk("grant_onehot", 32'($onehot(grant)), 32'd1);
      see(0, idx_of(grant), 0, 0, 0);
    end
    if (plot === 1'b1) see(2, 0, int'(x), int'(y), int'(colour));
    if (done != 3'b000) begin
      chk("done_onehot", 32'($onehot(done)), 32'd1);
      see(1, idx_of(done), 0, 0, 0);
    end
  end

  task automatic push(input int kind, input int idx, input int ex, input int ey, input int ec, input int ecyc);
    ev_t e;
    e.kind = kind; e.idx = idx; e.x = ex; e.y = ey; e.col = ec; e.cyc = ecyc;
    q.push_back(e);
  endtask

  // Job whose req edge ends cycle s: grant s+1, plots s+1.., done s+257 (or s+2 if skipped).
  task automatic push_job(input int i, input int cx, input int cy, input int col, input int s,
                          input int nplots, input bit with_done, input bit skip);
    push(0, i, 0, 0, 0, s + 1);
    if (!skip)
      for (int k = 0; k < nplots; k++)
        push(2, 0, cx*16 + k%16, cy*16 + k/16, col, s + 1 + k);
    if (with_done) push(1, i, 0, 0, 0, skip ? s + 2 : s + 257);
  endtask

  task automatic set_op(input int i, input int cx, input int cy, input int col);
    req_cell_x[6*i +: 6] = 6'(cx);
    req_cell_y[6*i +: 6] = 6'(cy);
    req_colour[3*i +: 3] = 3'(col);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"},  32'(grant),  32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_plot"},   32'(plot),   32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_x"},      32'(x),      32'd0);
    chk({tag, "_y"},      32'(y),      32'd0);
    chk({tag, "_colour"}, 32'(colour), 32'd0);
  endtask

  initial begin
    int s;
    resetn = 1'b0;
    req = '0; req_cell_x = '0; req_cell_y = '0; req_colour = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");

    // Contention: all three requesting from reset release; grants 0,1,2,0.
    set_op(0, 3, 4, 1);
    set_op(1, 5, 6, 2);
    set_op(2, 7, 8, 3);
    req = 3'b111;
    resetn = 1'b1;
    s = cyc;
    push_job(0, 3, 4, 1, s,       256, 1, 0);
    push_job(1, 5, 6, 2, s + 257, 256, 1, 0);
    push_job(2, 7, 8, 3, s + 514, 256, 1, 0);
    push_job(0, 3, 4, 1, s + 771, 256, 1, 0);
    wait_cyc(s + 258); req[1] = 1'b0;
    wait_cyc(s + 515); req[2] = 1'b0;
    wait_cyc(s + 772); req[0] = 1'b0;
    drain();

    // Single job at cell (0,0), colour 4.
    set_op(0, 0, 0, 4);
    req[0] = 1'b1;
    s = cyc;
    push_job(0, 0, 0, 4, s, 256, 1, 0);
    wait_cyc(s + 1); req[0] = 1'b0;
    chk("single_busy_c1", 32'(busy), 32'd1);
    wait_cyc(s + 256);
    chk("single_busy_c256", 32'(busy), 32'd1);
    wait_cyc(s + 257);
    chk("single_busy_c257", 32'(busy), 32'd0);
    drain();

    // Corner cell (39,29): plots 624..639 x 464..479.
    set_op(2, 39, 29, 3);
    req[2] = 1'b1;
    s = cyc;
    push_job(2, 39, 29, 3, s, 256, 1, 0);
    wait_cyc(s + 1); req[2] = 1'b0;
    drain();

    // Invalid cell (40,5): grant, no plots, done next cycle; outputs hold.
    set_op(1, 40, 5, 6);
    req[1] = 1'b1;
    s = cyc;
    push_job(1, 40, 5, 6, s, 0, 1, 1);
    wait_cyc(s + 1); req[1] = 1'b0;
    chk("skip_busy_c1", 32'(busy), 32'd1);
    wait_cyc(s + 2);
    chk("skip_busy_c2", 32'(busy), 32'd0);
    chk("skip_hold_x", 32'(x), 32'd639);
    chk("skip_hold_y", 32'(y), 32'd479);
    chk("skip_hold_col", 32'(colour), 32'd3);
    drain();

    // Operands change after grant: job keeps the latched cell (5,7).
    set_op(1, 5, 7, 2);
    req[1] = 1'b1;
    s = cyc;
    push_job(1, 5, 7, 2, s, 256, 1, 0);
    wait_cyc(s + 1); req[1] = 1'b0;
    wait_cyc(s + 2); set_op(1, 33, 1, 5);
    drain();

    // Mid-draw reset at the 100th plot of a requester-0 job (pointer then 1).
    set_op(0, 10, 3, 7);
    req[0] = 1'b1;
    s = cyc;
    push_job(0, 10, 3, 7, s, 100, 0, 0);
    wait_cyc(s + 1); req[0] = 1'b0;
    wait_cyc(s + 100);
    #2 resetn = 1'b0;
    #1 chk_reset_outs("midreset");
    chk("midreset_queue", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk_reset_outs("midreset_hold");

    // After release, 0 and 1 together: pointer back at 0 so 0 wins first.
    set_op(0, 1, 1, 5);
    set_op(1, 2, 2, 6);
    req = 3'b011;
    resetn = 1'b1;
    s = cyc;
    push_job(0, 1, 1, 5, s,       256, 1, 0);
    push_job(1, 2, 2, 6, s + 257, 256, 1, 0);
    wait_cyc(s + 1);   req[0] = 1'b0;
    wait_cyc(s + 258); req[1] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
